imem_boot_ctrl: RTL and testbench

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

---
 rtl/imem_boot_ctrl_if.sv | 35 +++
 rtl/imem_boot_ctrl.sv | 124 ++++++++++++
 tb/tb_imem_boot_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_ctrl_if.sv
// Bundles the program-load stream, CPU fetch port and instruction-memory port.
// Latency: none (wires only).
// Backpressure: load channel is valid/ready; the slave side owns load_ready.
interface imem_boot_ctrl_if #(
    parameter int AW = 6
);
    logic          load_valid;
    logic          load_ready;
    logic [31:0]   load_data;
    logic          load_last;

    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_instr;
    logic          cpu_stall;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;

    // Controller view
    modport slave (
        input  load_valid, load_data, load_last, cpu_addr, mem_rdata,
        output load_ready, cpu_instr, cpu_stall,
               mem_we, mem_waddr, mem_wdata, mem_raddr
    );

    // Environment view: loader, CPU and memory
    modport master (
        output load_valid, load_data, load_last, cpu_addr, mem_rdata,
        input  load_ready, cpu_instr, cpu_stall,
               mem_we, mem_waddr, mem_wdata, mem_raddr
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Clears instruction memory, streams a program into it, then releases the CPU.
// Latency: clear takes DEPTH cycles; each accepted load word is written the same cycle.
// Backpressure: load_ready is high only in LOAD; words offered elsewhere are not taken.
module imem_boot_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    imem_boot_ctrl_if.slave bus,
    output logic           done,
    output logic           err_overflow,
    output logic           err_fetch,
    output logic [AW:0]    word_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] ptr;
    logic          accept;
    logic          fetch_ok;

    // State register; reset drops straight back to IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state memory/handshake outputs
    always_comb begin
        state_nxt      = state;
        bus.load_ready = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_wdata  = 32'h0;
        accept         = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                // Zero-fill one word per cycle; start is deliberately ignored here
                bus.mem_we = 1'b1;
                if (ptr == LAST_ADDR) state_nxt = LOAD;
            end
            LOAD: begin
                bus.load_ready = 1'b1;
                accept         = bus.load_valid;
                bus.mem_we     = accept;
                bus.mem_wdata  = bus.load_data;
                // Last-flagged word or a full memory both end the load
                if (accept && (bus.load_last || ptr == LAST_ADDR)) state_nxt = RUN;
            end
            RUN: begin
                if (start) state_nxt = CLEAR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write pointer, word count and sticky overflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr          <= '0;
            word_count   <= '0;
            err_overflow <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    ptr <= (ptr == LAST_ADDR) ? '0 : ptr + AW'(1);
                end
                LOAD: begin
                    if (accept) begin
                        if (bus.load_last) begin
                            word_count <= {1'b0, ptr} + (AW+1)'(1);
                            ptr        <= '0;
                        end else if (ptr == LAST_ADDR) begin
                            // Program is longer than memory: keep what fits and flag it
                            err_overflow <= 1'b1;
                            word_count   <= (AW+1)'(DEPTH);
                            ptr          <= '0;
                        end else begin
                            ptr <= ptr + AW'(1);
                        end
                    end
                end
                RUN: begin
                    if (start) begin
                        err_overflow <= 1'b0;
                        ptr          <= '0;
                    end
                end
                default: ptr <= '0;
            endcase
        end
    end

    assign bus.mem_waddr = ptr;
    assign bus.mem_raddr = bus.cpu_addr[AW+1:2];

    // Word-aligned and inside the memory window
    assign fetch_ok = (bus.cpu_addr[1:0] == 2'b00) && (bus.cpu_addr[31:AW+2] == '0);

    // CPU side: run only in RUN, feed NOPs for any bad fetch
    always_comb begin
        done          = (state == RUN);
        bus.cpu_stall = (state != RUN);
        err_fetch     = (state == RUN) && !fetch_ok;
        bus.cpu_instr = ((state == RUN) && fetch_ok) ? bus.mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a behavioural 64-word memory.
// Inputs change 1ns after the falling edge; outputs are sampled before the next rising edge.
// Writes are logged on the rising edge to count them and check address contiguity.
module tb_imem_boot_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic        err_overflow;
    logic        err_fetch;
    logic [6:0]  word_count;

    imem_boot_ctrl_if #(.AW(6)) bus ();

    imem_boot_ctrl #(.DEPTH(64), .AW(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .done         (done),
        .err_overflow (err_overflow),
        .err_fetch    (err_fetch),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    // Memory model and write monitor
    logic [31:0] mmem [64];
    logic        mon_clr = 1'b0;
    int          wr_cnt = 0;
    int          wr_bad = 0;
    int          exp_addr = 0;

    assign bus.mem_rdata = mmem[bus.mem_raddr];

    always @(posedge clk) begin
        if (mon_clr) begin
            wr_cnt   = 0;
            wr_bad   = 0;
            exp_addr = 0;
        end
        if (bus.mem_we) begin
            if (int'(bus.mem_waddr) != exp_addr) wr_bad++;
            mmem[bus.mem_waddr] = bus.mem_wdata;
            wr_cnt++;
            exp_addr++;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Program word table for the 18-word load
    function automatic logic [31:0] prog_word(input int i);
        if (i == 0)       return 32'h2008_0005;
        else if (i == 17) return 32'h200F_000C;
        else              return 32'h2010_0000 + 32'(i);
    endfunction

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 200; k++) begin
            if (bus.load_ready) break;
            @(negedge clk);
            #1;
        end
        check(tag, 32'(bus.load_ready), 32'd1);
    endtask

    initial begin
        int nz;
        int idle_bad;

        reset          = 1'b0;
        start          = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 32'h0;
        bus.load_last  = 1'b0;
        bus.cpu_addr   = 32'h0;

        // Reset values
        @(negedge clk);
        #1;
        check("rst_stall",      32'(bus.cpu_stall),  32'd1);
        check("rst_done",       32'(done),           32'd0);
        check("rst_ready",      32'(bus.load_ready), 32'd0);
        check("rst_we",         32'(bus.mem_we),     32'd0);
        check("rst_count",      32'(word_count),     32'd0);
        check("rst_ovf",        32'(err_overflow),   32'd0);
        check("rst_instr",      bus.cpu_instr,       32'h0);
        check("rst_err_fetch",  32'(err_fetch),      32'd0);

        // Clear: 64 zero writes at 0..63, then ready
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start   = 1'b1;
        mon_clr = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        mon_clr = 1'b0;
        #1;
        check("clr_first_we",   32'(bus.mem_we),    32'd1);
        check("clr_first_addr", 32'(bus.mem_waddr), 32'd0);
        wait_ready("clr_ready");
        check("clr_writes",     32'(wr_cnt),        32'd64);
        check("clr_contig",     32'(wr_bad),        32'd0);
        nz = 0;
        for (int i = 0; i < 64; i++) if (mmem[i] !== 32'h0) nz++;
        check("clr_zero",       32'(nz),            32'd0);

        // 18-word load with valid toggling every other cycle
        idle_bad = 0;
        for (int i = 0; i < 18; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = prog_word(i);
            bus.load_last  = (i == 17);
            mon_clr        = (i == 0);
            @(negedge clk);
            mon_clr        = 1'b0;
            bus.load_valid = 1'b0;
            bus.load_last  = 1'b0;
            #1;
            if (bus.mem_we) idle_bad++;
            @(negedge clk);
            #1;
        end
        check("ld_writes",      32'(wr_cnt),         32'd18);
        check("ld_contig",      32'(wr_bad),         32'd0);
        check("ld_idle_we",     32'(idle_bad),       32'd0);
        check("ld_count",       32'(word_count),     32'd18);
        check("ld_done",        32'(done),           32'd1);
        check("ld_stall",       32'(bus.cpu_stall),  32'd0);
        check("ld_ready_run",   32'(bus.load_ready), 32'd0);
        check("ld_mem18_zero",  mmem[18],            32'h0);
        bus.cpu_addr = 32'h44;
        #1;
        check("fetch44_raddr",  32'(bus.mem_raddr),  32'd17);
        check("fetch44_instr",  bus.cpu_instr,       32'h200F_000C);
        check("fetch44_err",    32'(err_fetch),      32'd0);
        bus.cpu_addr = 32'h0;
        #1;
        check("fetch0_instr",   bus.cpu_instr,       32'h2008_0005);

        // Invalid fetches: misaligned and out of range
        bus.cpu_addr = 32'h102;
        #1;
        check("fetch102_instr", bus.cpu_instr,       32'h0);
        check("fetch102_err",   32'(err_fetch),      32'd1);
        bus.cpu_addr = 32'h100;
        #1;
        check("fetch100_instr", bus.cpu_instr,       32'h0);
        check("fetch100_err",   32'(err_fetch),      32'd1);

        // Restart from RUN
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("rs1_stall",      32'(bus.cpu_stall),  32'd1);
        check("rs1_done",       32'(done),           32'd0);
        check("rs1_err_fetch",  32'(err_fetch),      32'd0);
        wait_ready("rs1_ready");

        // Overflow: 70 words, no last flag; start mid-load must be ignored
        for (int i = 0; i < 70; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'hA000_0000 + 32'(i);
            bus.load_last  = 1'b0;
            mon_clr        = (i == 0);
            start          = (i == 10);
            @(negedge clk);
            #1;
        end
        bus.load_valid = 1'b0;
        mon_clr        = 1'b0;
        start          = 1'b0;
        check("ovf_writes",     32'(wr_cnt),         32'd64);
        check("ovf_contig",     32'(wr_bad),         32'd0);
        check("ovf_flag",       32'(err_overflow),   32'd1);
        check("ovf_count",      32'(word_count),     32'd64);
        check("ovf_done",       32'(done),           32'd1);
        check("ovf_ready",      32'(bus.load_ready), 32'd0);
        check("ovf_mem0",       mmem[0],             32'hA000_0000);
        check("ovf_mem63",      mmem[63],            32'hA000_003F);

        // Restart clears overflow and done
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("rs2_ovf",        32'(err_overflow),   32'd0);
        check("rs2_done",       32'(done),           32'd0);
        check("rs2_stall",      32'(bus.cpu_stall),  32'd1);
        check("rs2_we",         32'(bus.mem_we),     32'd1);
        wait_ready("rs2_ready");

        // Reset in the middle of a load
        for (int i = 0; i < 5; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'h5000_0000 + 32'(i);
            mon_clr        = (i == 0);
            @(negedge clk);
            #1;
        end
        mon_clr = 1'b0;
        check("mid_writes",     32'(wr_cnt),         32'd5);
        check("mid_we_before",  32'(bus.mem_we),     32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_stall",  32'(bus.cpu_stall),  32'd1);
        check("mid_rst_done",   32'(done),           32'd0);
        check("mid_rst_ready",  32'(bus.load_ready), 32'd0);
        check("mid_rst_we",     32'(bus.mem_we),     32'd0);
        check("mid_rst_count",  32'(word_count),     32'd0);
        check("mid_rst_instr",  bus.cpu_instr,       32'h0);
        bus.load_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_ready", 32'(bus.load_ready), 32'd0);
        check("post_rst_stall", 32'(bus.cpu_stall),  32'd1);
        check("post_rst_we",    32'(bus.mem_we),     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
